// File: rtl/spi_master_24.sv
// SPI mode-0 master for the front-panel LCD/switch controller: one n_cs-framed,
// MSB-first transfer per accepted start, with a captured MISO word and done pulse.
module spi_master_24 #(
  parameter int DATA_WIDTH  = 24,
  parameter int HALF_PERIOD = 2,
  parameter int CS_SETUP    = 2,
  parameter int CS_HOLD     = 2,
  parameter int CS_IDLE     = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_spi_start,
  input  logic [DATA_WIDTH-1:0] i_mosi_data,
  output logic [DATA_WIDTH-1:0] o_miso_data,
  output logic                  o_spi_done,
  output logic                  o_busy,
  output logic                  n_cs,
  output logic                  o_sclk,
  output logic                  o_mosi,
  input  logic                  i_miso
);

  localparam int M1   = (HALF_PERIOD > CS_SETUP) ? HALF_PERIOD : CS_SETUP;
  localparam int M2   = (CS_HOLD > CS_IDLE) ? CS_HOLD : CS_IDLE;
  localparam int MAXC = (M1 > M2) ? M1 : M2;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int FW   = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [FW-1:0]         fall_cnt_q, fall_cnt_d;
  logic [DATA_WIDTH-1:0] tx_q, tx_d;
  logic [DATA_WIDTH-1:0] rx_q, rx_d;
  logic [DATA_WIDTH-1:0] miso_data_q, miso_data_d;
  logic [DATA_WIDTH-1:0] tx_shift;
  logic                  sclk_q, sclk_d;
  logic                  mosi_q, mosi_d;
  logic                  ncs_q, ncs_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      fall_cnt_q  <= '0;
      tx_q        <= '0;
      rx_q        <= '0;
      miso_data_q <= '0;
      sclk_q      <= 1'b0;
      mosi_q      <= 1'b0;
      ncs_q       <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      fall_cnt_q  <= fall_cnt_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      miso_data_q <= miso_data_d;
      sclk_q      <= sclk_d;
      mosi_q      <= mosi_d;
      ncs_q       <= ncs_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    fall_cnt_d  = fall_cnt_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    miso_data_d = miso_data_q;
    sclk_d      = sclk_q;
    mosi_d      = mosi_q;
    ncs_d       = ncs_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    tx_shift    = tx_q << 1;

    unique case (state_q)
      IDLE: begin
        // busy may already be high here when a held start was seen at GAP exit
        busy_d = i_spi_start;
        if (i_spi_start) begin
          tx_d       = i_mosi_data;
          mosi_d     = i_mosi_data[DATA_WIDTH-1];
          ncs_d      = 1'b0;
          cnt_d      = '0;
          fall_cnt_d = '0;
          rx_d       = '0;
          state_d    = SETUP;
        end
      end
      SETUP: begin
        if (cnt_q == CW'(CS_SETUP - 1)) begin
          cnt_d   = '0;
          sclk_d  = 1'b0;
          state_d = SHIFT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      SHIFT: begin
        // first cycle of a high half: i_miso is sampled while o_sclk is already 1
        if (sclk_q && cnt_q == '0) begin
          rx_d    = rx_q << 1;
          rx_d[0] = i_miso;
        end
        if (cnt_q == CW'(HALF_PERIOD - 1)) begin
          cnt_d  = '0;
          sclk_d = ~sclk_q;
          if (sclk_q) begin
            if (fall_cnt_q == FW'(DATA_WIDTH - 1)) begin
              state_d = HOLD;
            end else begin
              fall_cnt_d = fall_cnt_q + FW'(1);
              tx_d       = tx_shift;
              mosi_d     = tx_shift[DATA_WIDTH-1];
            end
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      HOLD: begin
        if (cnt_q == CW'(CS_HOLD - 1)) begin
          cnt_d       = '0;
          ncs_d       = 1'b1;
          done_d      = 1'b1;
          miso_data_d = rx_q;
          mosi_d      = 1'b0;
          state_d     = GAP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      GAP: begin
        if (cnt_q == CW'(CS_IDLE - 1)) begin
          cnt_d   = '0;
          busy_d  = i_spi_start;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign o_miso_data = miso_data_q;
  assign o_spi_done  = done_q;
  assign o_busy      = busy_q;
  assign n_cs        = ncs_q;
  assign o_sclk      = sclk_q;
  assign o_mosi      = mosi_q;

endmodule

// File: tb/tb_spi_master_24.sv
// Self-checking bench for spi_master_24: default instance plus a fast-timing instance,
// with a behavioural SPI slave and frame timing derived from the frame-length formula.
module tb_spi_master_24;

  localparam int DW = 24;
  localparam int HP0 = 2, SU0 = 2, HO0 = 2;
  localparam int HP1 = 1, SU1 = 1, HO1 = 1;
  localparam int T_DONE0 = 1 + SU0 + 2 * DW * HP0 + HO0;
  localparam int T_DONE1 = 1 + SU1 + 2 * DW * HP1 + HO1;

  logic          clk = 1'b0;
  logic          rst;
  logic          start0, start1;
  logic [DW-1:0] data;
  logic          loop_mode;
  logic [DW-1:0] slave_word, slv_sh, slv_rx;
  logic          ncs_prev;

  logic [DW-1:0] miso_data0, miso_data1;
  logic          done0, busy0, ncs0, sclk0, mosi0, miso0;
  logic          done1, busy1, ncs1, sclk1, mosi1;

  int            tests, fails;
  int            cyc, done_cnt, first_done, ncs_low, rises, busy_low;
  int            min_gap, high_run, first_rise, last_rise;
  logic          seen_low, prev_sclk;
  logic [DW-1:0] exp_word, w;

  always #5 clk = ~clk;

  assign miso0 = loop_mode ? mosi0 : slv_sh[DW-1];

  spi_master_24 u_dut0 (
    .i_clk(clk), .i_rst(rst), .i_spi_start(start0), .i_mosi_data(data),
    .o_miso_data(miso_data0), .o_spi_done(done0), .o_busy(busy0),
    .n_cs(ncs0), .o_sclk(sclk0), .o_mosi(mosi0), .i_miso(miso0)
  );

  spi_master_24 #(
    .DATA_WIDTH(DW), .HALF_PERIOD(HP1), .CS_SETUP(SU1), .CS_HOLD(HO1), .CS_IDLE(1)
  ) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_spi_start(start1), .i_mosi_data(data),
    .o_miso_data(miso_data1), .o_spi_done(done1), .o_busy(busy1),
    .n_cs(ncs1), .o_sclk(sclk1), .o_mosi(mosi1), .i_miso(mosi1)
  );

  // Slave device: loads its reply when n_cs falls, shifts on SCLK falling edges
  always @(ncs0 or negedge sclk0) begin
    if (ncs0 !== ncs_prev) begin
      ncs_prev = ncs0;
      if (!ncs0) slv_sh = slave_word;
    end else if (!ncs0) begin
      slv_sh = slv_sh << 1;
    end
  end

  always @(posedge sclk0) begin
    if (!ncs0) slv_rx = {slv_rx[DW-2:0], mosi0};
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv)
    else begin
      fails++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic clearMon();
    cyc = 0; done_cnt = 0; first_done = -1; ncs_low = 0; rises = 0; busy_low = 0;
    min_gap = 1000; high_run = 0; seen_low = 1'b0; prev_sclk = 1'b0;
    first_rise = -1; last_rise = -1;
  endtask

  // Samples the selected instance on falling clock edges, away from the active edge
  task automatic observe(input int sel, input int n);
    logic s_ncs, s_sclk, s_busy, s_done;
    logic [DW-1:0] s_miso;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cyc++;
      s_ncs  = sel != 0 ? ncs1 : ncs0;
      s_sclk = sel != 0 ? sclk1 : sclk0;
      s_busy = sel != 0 ? busy1 : busy0;
      s_done = sel != 0 ? done1 : done0;
      s_miso = sel != 0 ? miso_data1 : miso_data0;
      if (s_sclk && !prev_sclk) begin
        rises++;
        if (first_rise < 0) first_rise = cyc;
        last_rise = cyc;
      end
      prev_sclk = s_sclk;
      if (!s_ncs) begin
        ncs_low++;
        if (seen_low && high_run > 0 && high_run < min_gap) min_gap = high_run;
        high_run = 0;
        seen_low = 1'b1;
      end else begin
        high_run++;
      end
      if (!s_busy) busy_low++;
      if (s_done) begin
        done_cnt++;
        if (first_done < 0) first_done = cyc;
        checkOutput("miso_at_done", 32'(s_miso), 32'(exp_word));
      end
    end
  endtask

  task automatic applyStimulus(input int sel, input logic [DW-1:0] word);
    data = word;
    if (sel != 0) start1 = 1'b1;
    else start0 = 1'b1;
  endtask

  task automatic runFrame(input int sel, input logic [DW-1:0] word,
                          input logic [DW-1:0] expw, input int total);
    clearMon();
    exp_word = expw;
    applyStimulus(sel, word);
    observe(sel, 1);
    start0 = 1'b0;
    start1 = 1'b0;
    observe(sel, total - 1);
  endtask

  initial begin
    tests = 0; fails = 0;
    rst = 1'b1; start0 = 1'b0; start1 = 1'b0; data = '0;
    loop_mode = 1'b1; slave_word = '0; slv_sh = '0; slv_rx = '0; ncs_prev = 1'b1;
    exp_word = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_ncs", 32'(ncs0), 32'd1);
    checkOutput("rst_sclk", 32'(sclk0), 32'd0);
    checkOutput("rst_mosi", 32'(mosi0), 32'd0);
    checkOutput("rst_busy", 32'(busy0), 32'd0);
    checkOutput("rst_done", 32'(done0), 32'd0);
    checkOutput("rst_miso_data", 32'(miso_data0), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Loopback with the reference word
    runFrame(0, 24'hA53C0F, 24'hA53C0F, 110);
    checkOutput("lb_done_cnt", 32'(done_cnt), 32'd1);
    checkOutput("lb_done_cycle", 32'(first_done), 32'(T_DONE0));
    checkOutput("lb_ncs_low", 32'(ncs_low), 32'(T_DONE0 - 1));
    checkOutput("lb_rises", 32'(rises), 32'(DW));
    checkOutput("lb_first_rise", 32'(first_rise), 32'(1 + SU0 + HP0));
    checkOutput("lb_rise_span", 32'(last_rise - first_rise), 32'(2 * HP0 * (DW - 1)));
    checkOutput("lb_miso_data", 32'(miso_data0), 32'h00A53C0F);
    checkOutput("lb_idle_busy", 32'(busy0), 32'd0);
    checkOutput("lb_idle_mosi", 32'(mosi0), 32'd0);

    // Random loopback words
    for (int k = 0; k < 3; k++) begin
      w = 24'($urandom);
      runFrame(0, w, w, 108);
      checkOutput("rlb_done_cnt", 32'(done_cnt), 32'd1);
      checkOutput("rlb_done_cycle", 32'(first_done), 32'(T_DONE0));
      checkOutput("rlb_miso_data", 32'(miso_data0), 32'(w));
    end

    // Slave replies while master transmits
    loop_mode = 1'b0;
    slave_word = 24'h123456;
    runFrame(0, 24'hFFFFFF, 24'h123456, 108);
    checkOutput("slv_done_cnt", 32'(done_cnt), 32'd1);
    checkOutput("slv_miso_data", 32'(miso_data0), 32'h00123456);
    checkOutput("slv_captured", 32'(slv_rx), 32'h00FFFFFF);
    for (int k = 0; k < 2; k++) begin
      slave_word = 24'($urandom);
      w = 24'($urandom);
      runFrame(0, w, slave_word, 108);
      checkOutput("rslv_miso_data", 32'(miso_data0), 32'(slave_word));
      checkOutput("rslv_captured", 32'(slv_rx), 32'(w));
    end
    loop_mode = 1'b1;

    // A start while busy is ignored and new data does not disturb the frame
    w = 24'($urandom);
    clearMon();
    exp_word = w;
    applyStimulus(0, w);
    observe(0, 1);
    start0 = 1'b0;
    observe(0, 19);
    applyStimulus(0, 24'h000001);
    observe(0, 1);
    start0 = 1'b0;
    observe(0, 89);
    checkOutput("ign_done_cnt", 32'(done_cnt), 32'd1);
    checkOutput("ign_done_cycle", 32'(first_done), 32'(T_DONE0));
    checkOutput("ign_rises", 32'(rises), 32'(DW));
    checkOutput("ign_miso_data", 32'(miso_data0), 32'(w));

    // Held start: three back-to-back frames
    w = 24'($urandom);
    clearMon();
    exp_word = w;
    applyStimulus(0, w);
    observe(0, 311);
    checkOutput("b2b_done_cnt", 32'(done_cnt), 32'd3);
    checkOutput("b2b_first_done", 32'(first_done), 32'(T_DONE0));
    checkOutput("b2b_busy_low", 32'(busy_low), 32'd0);
    checkOutput("b2b_gap_ok", 32'(min_gap >= 4 && min_gap < 1000), 32'd1);
    start0 = 1'b0;
    observe(0, 15);
    checkOutput("b2b_done_total", 32'(done_cnt), 32'd3);
    checkOutput("b2b_end_busy", 32'(busy0), 32'd0);

    // Refresh o_miso_data with a nonzero word, then reset mid-frame
    w = 24'($urandom) | 24'h800000;
    runFrame(0, w, w, 108);
    checkOutput("pre_rst_miso", 32'(miso_data0), 32'(w));
    clearMon();
    exp_word = w;
    applyStimulus(0, 24'($urandom));
    observe(0, 1);
    start0 = 1'b0;
    observe(0, 49);
    #2 rst = 1'b1;
    #1;
    checkOutput("arst_ncs", 32'(ncs0), 32'd1);
    checkOutput("arst_sclk", 32'(sclk0), 32'd0);
    checkOutput("arst_miso_data", 32'(miso_data0), 32'd0);
    checkOutput("arst_busy", 32'(busy0), 32'd0);
    observe(0, 5);
    checkOutput("arst_no_done", 32'(done_cnt), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    w = 24'($urandom);
    runFrame(0, w, w, 108);
    checkOutput("post_rst_done_cycle", 32'(first_done), 32'(T_DONE0));
    checkOutput("post_rst_miso", 32'(miso_data0), 32'(w));

    // Fast-timing instance
    runFrame(1, 24'h800001, 24'h800001, 60);
    checkOutput("fast_done_cnt", 32'(done_cnt), 32'd1);
    checkOutput("fast_done_cycle", 32'(first_done), 32'(T_DONE1));
    checkOutput("fast_ncs_low", 32'(ncs_low), 32'(T_DONE1 - 1));
    checkOutput("fast_rises", 32'(rises), 32'(DW));
    checkOutput("fast_rise_span", 32'(last_rise - first_rise), 32'(2 * HP1 * (DW - 1)));
    checkOutput("fast_miso_data", 32'(miso_data1), 32'h00800001);
    w = 24'($urandom);
    runFrame(1, w, w, 58);
    checkOutput("fast_rand_miso", 32'(miso_data1), 32'(w));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/spi_master_24.md
Name: spi_master_24

Overview:
- SPI master engine (mode 0) that serves the front-panel LCD/switch controller.
- Accepts a start request plus a 24-bit command word, then drives one n_cs-framed transaction of DATA_WIDTH bits, MSB first.
- Returns the captured MISO word with a one-cycle done pulse.
- Sits between the front-panel controller and the external LCD/switch chip-select steering logic; n_cs is the framing signal that logic routes to the LCD or switch device.

Parameters:
DATA_WIDTH, 24, bits per frame (≥1).
HALF_PERIOD, 2, i_clk cycles per SCLK half-period (≥1).
CS_SETUP, 2, cycles from n_cs falling to the start of the first SCLK low half (≥1).
CS_HOLD, 2, cycles from the last SCLK falling edge to n_cs rising (≥1).
CS_IDLE, 4, minimum n_cs-high cycles before the next frame may begin (≥1).

Ports:
i_clk  in  1  system clock
i_rst  in  1  asynchronous reset, active-high
i_spi_start  in  1  start request, sampled only in IDLE
i_mosi_data  in  DATA_WIDTH  transmit word, latched when start is accepted
o_miso_data  out  DATA_WIDTH  last received word, updated at frame end
o_spi_done  out  1  one-cycle pulse at frame end
o_busy  out  1  high from start acceptance until the engine returns to IDLE
n_cs  out  1  chip select, active-low
o_sclk  out  1  serial clock, idles low
o_mosi  out  1  serial data out
i_miso  in  1  serial data in

Behaviour:
- Reset (async, any state):
  - n_cs=1, o_sclk=0, o_mosi=0, o_busy=0, o_spi_done=0, o_miso_data=0.
  - Counters and shift registers clear; state goes to IDLE.
  - Reset mid-frame aborts immediately; no done pulse is produced.
- States: IDLE, SETUP, SHIFT, HOLD, GAP.
- IDLE:
  - If i_spi_start=1 at a clock edge (cycle t0), latch i_mosi_data into the tx shift register.
  - At t0+1: n_cs=0, o_busy=1, o_mosi=tx[MSB]; go to SETUP.
  - i_spi_start is level-sampled. Holding it high produces back-to-back frames separated by GAP.
- SETUP: hold for CS_SETUP cycles, then go to SHIFT.
- SHIFT:
  - A half-period counter toggles o_sclk every HALF_PERIOD cycles, starting with a low half.
  - On each SCLK rising transition, the rx shift register takes i_miso at its LSB (shift-left), sampled in the same cycle o_sclk goes 1.
  - On each SCLK falling transition, except the last, the tx register shifts left and o_mosi shows the new MSB.
  - After DATA_WIDTH rising edges and the following falling edge, go to HOLD with o_sclk=0.
  - Exactly DATA_WIDTH rising edges per frame.
  - Rising edge k (0-based) occurs HALF_PERIOD·(2k+1) cycles after SHIFT entry.
- HOLD:
  - Hold for CS_HOLD cycles.
  - On exit: n_cs=1, o_miso_data<=rx register, o_spi_done=1 for that cycle only, o_mosi=0; go to GAP.
- GAP:
  - Hold for CS_IDLE cycles, then go to IDLE and drop o_busy.
  - o_busy stays high throughout GAP.
- Timing:
  - n_cs rises at t0 + 1 + CS_SETUP + 2·DATA_WIDTH·HALF_PERIOD + CS_HOLD.
  - With defaults this is t0+101.
  - The next start can be accepted no earlier than CS_IDLE cycles after n_cs rises.
- Start handling:
  - i_spi_start while o_busy=1 is ignored; it is not queued.
  - i_mosi_data changes after acceptance do not affect the frame in progress.
- Outputs:
  - o_miso_data holds its value between frames; it changes only in the done cycle.
  - All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Loopback (i_miso tied to o_mosi), defaults, start with i_mosi_data=0xA53C0F → 24 SCLK rising edges; o_spi_done pulses once, 101 cycles after start acceptance; o_miso_data=0xA53C0F; n_cs low for exactly 100 cycles.
- Slave model returns 0x123456 MSB-first, shifting on SCLK falling edges; master sends 0xFFFFFF → o_miso_data=0x123456; slave captures 0xFFFFFF.
- Second start pulse 20 cycles into a frame with i_mosi_data=0x000001 → ignored; only one frame and one done pulse; o_miso_data reflects only the first frame.
- i_spi_start held high for 3 frames → three done pulses; n_cs high for ≥4 cycles between frames; o_busy stays high across the gaps.
- Assert i_rst at cycle 50 of a frame → n_cs=1 and o_sclk=0 with no clock edge needed; no done pulse; o_miso_data=0; the next start after release produces a normal frame.
- HALF_PERIOD=1, CS_SETUP=CS_HOLD=CS_IDLE=1, loopback 0x800001 → o_sclk period 2 cycles; o_miso_data=0x800001; done pulse at t0+51.
